aha_axi_wr_arbiter: RTL and testbench
=====================================

Name: aha_axi_wr_arbiter

Overview:
- Two-master AXI4 write-channel arbiter in front of the single AXI-to-SIF write bridge in the Garnet integration layer.
- Grants one master a whole transaction at a time: AW, then all W beats, then B.
- Routes AW, W and B accordingly.
- Only one transaction is outstanding downstream at any time, matching the bridge's single-burst SIF write model.

Parameters:
- ID_WIDTH, 4, AXI ID width; passed through unchanged on AW and B.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-low.
- Sn_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/32/8/3/2  slave-side AW payload; n = 0,1 (each a separate port).
- Sn_AWVALID  in  1 / Sn_AWREADY  out  1  AW handshake, per master.
- Sn_WDATA/WSTRB/WLAST  in  64/8/1  W payload, per master.
- Sn_WVALID  in  1 / Sn_WREADY  out  1  W handshake, per master.
- Sn_BID/BRESP  out  ID_WIDTH/2  B payload, per master.
- Sn_BVALID  out  1 / Sn_BREADY  in  1  B handshake, per master.
- M_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  ID_WIDTH/32/8/3/2  to bridge.
- M_AWVALID  out  1 / M_AWREADY  in  1.
- M_WDATA/WSTRB/WLAST  out  64/8/1.
- M_WVALID  out  1 / M_WREADY  in  1.
- M_BID/BRESP  in  ID_WIDTH/2.
- M_BVALID  in  1 / M_BREADY  out  1.
- GRANT  out  2  one-hot owner; 0 when idle.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (ARESETn low at a clock edge):
  - state = IDLE, grant = none, last_winner = 1 (master 0 wins first tie).
  - Outputs next cycle: all VALID/READY outputs 0, GRANT = 0, BUSY = 0.
- States and transitions:
  - IDLE: if any Sn_AWVALID is high, pick a winner, register grant, go to AW. No output handshakes in IDLE.
  - AW:
    - M_AW* = winner's payload; M_AWVALID = winner AWVALID.
    - Winner AWREADY = M_AWREADY; loser AWREADY = 0.
    - On M_AWVALID & M_AWREADY go to W.
  - W:
    - M_W* = winner's payload; M_WVALID = winner WVALID.
    - Winner WREADY = M_WREADY.
    - On handshake with WLAST go to B.
  - B:
    - Winner BVALID = M_BVALID; winner BID/BRESP = M_BID/BRESP.
    - M_BREADY = winner BREADY.
    - On handshake: last_winner = winner, go to IDLE.
- Winner selection: round-robin. If both request, choose !last_winner; otherwise the sole requester.
- Latency: Sn_AWVALID to M_AWVALID is 1 cycle. W/B forwarding is combinational (0 cycles) once in state.
- Loser: all READY outputs and BVALID held 0 for the whole transaction; its Sn_B* payload driven 0.
- WLAST is the sole burst terminator. AWLEN is not counted.
- Early W: W beats presented before the owner's AW completes are not accepted; WREADY stays 0.
- Request withdrawn: if the winner's AWVALID drops in AW (an AXI protocol violation), the block stays in AW; no retiming.
- Back-to-back transactions: at least 1 IDLE cycle between transactions.
- Reset mid-transaction: returns to IDLE; any partial burst is abandoned (the bridge shares the reset).

Optional Feature:
- AHA_AXI_WR_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, master 0 always wins simultaneous requests; last_winner register removed.
  - Undefined: round-robin as above.

Decomposition:
- Package aha_axi_wr_arb_pkg:
  - state enum (IDLE, AW, W, B).
  - master index constants (M0 = 0, M1 = 1).
  - BRESP constants (OKAY = 2'b00).
- One sub-module, aha_rr_arb2: 2-way round-robin/fixed picker.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt.
  - Holds the ifdef'd priority logic.

Test Plan:
- Single master: S0 writes AWADDR = 0x1000, AWLEN = 3, 4 beats → M_AW* matches 1 cycle after S0_AWVALID; 4 W beats forwarded; S0 gets BRESP = 0; GRANT = 01 throughout; S1 readies stay 0.
- Tie: S0 and S1 assert AWVALID in the same cycle, repeated 3 times → grants alternate S0, S1, S0. With AHA_AXI_WR_ARB_FIXED_PRIO_EN → S0 every time while it keeps requesting.
- Backpressure: M_WREADY toggles each cycle during an 8-beat burst, M_BREADY held 0 by S1 for 5 cycles → no beat lost or duplicated; state holds in B until S1_BREADY = 1.
- Early W: S1 presents WVALID two cycles before its AWVALID → S1_WREADY = 0 until the AW handshake completes, then the data passes intact.
- Reset mid-burst: ARESETn low after beat 2 of 4 → next cycle all VALID/READY outputs 0, GRANT = 0, BUSY = 0; the next request from S1 after reset is served normally.
- ID passthrough: S1 AWID = 4'hA → M_AWID = 4'hA; M_BID = 4'hA routed to S1_BID only; S0_BVALID stays 0.

Source files
------------

// File: rtl/aha_axi_wr_arb_pkg.sv
// Shared types and constants for the two-master AXI4 write arbiter.
package aha_axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } arb_state_e;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

endpackage

// File: rtl/aha_rr_arb2.sv
// Two-way winner picker: round-robin on last winner, or fixed master-0
// priority when AHA_AXI_WR_ARB_FIXED_PRIO_EN is defined.
module aha_rr_arb2
    import aha_axi_wr_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef AHA_AXI_WR_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt     = '0;
        gnt[M0] = req[M0];
        gnt[M1] = req[M1] & ~req[M0];
    end
`else
    // On a tie the master that did not win last time goes first.
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end
`endif

endmodule

// File: rtl/aha_axi_wr_arbiter.sv
// Two-master AXI4 write arbiter: one whole AW/W/B transaction at a time.
// Optional AHA_AXI_WR_ARB_FIXED_PRIO_EN selects fixed master-0 priority.
module aha_axi_wr_arbiter
    import aha_axi_wr_arb_pkg::*;
#(
    parameter int ID_WIDTH = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic [ID_WIDTH-1:0] S0_AWID,
    input  logic [31:0]         S0_AWADDR,
    input  logic [7:0]          S0_AWLEN,
    input  logic [2:0]          S0_AWSIZE,
    input  logic [1:0]          S0_AWBURST,
    input  logic                S0_AWVALID,
    output logic                S0_AWREADY,
    input  logic [63:0]         S0_WDATA,
    input  logic [7:0]          S0_WSTRB,
    input  logic                S0_WLAST,
    input  logic                S0_WVALID,
    output logic                S0_WREADY,
    output logic [ID_WIDTH-1:0] S0_BID,
    output logic [1:0]          S0_BRESP,
    output logic                S0_BVALID,
    input  logic                S0_BREADY,

    input  logic [ID_WIDTH-1:0] S1_AWID,
    input  logic [31:0]         S1_AWADDR,
    input  logic [7:0]          S1_AWLEN,
    input  logic [2:0]          S1_AWSIZE,
    input  logic [1:0]          S1_AWBURST,
    input  logic                S1_AWVALID,
    output logic                S1_AWREADY,
    input  logic [63:0]         S1_WDATA,
    input  logic [7:0]          S1_WSTRB,
    input  logic                S1_WLAST,
    input  logic                S1_WVALID,
    output logic                S1_WREADY,
    output logic [ID_WIDTH-1:0] S1_BID,
    output logic [1:0]          S1_BRESP,
    output logic                S1_BVALID,
    input  logic                S1_BREADY,

    output logic [ID_WIDTH-1:0] M_AWID,
    output logic [31:0]         M_AWADDR,
    output logic [7:0]          M_AWLEN,
    output logic [2:0]          M_AWSIZE,
    output logic [1:0]          M_AWBURST,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [63:0]         M_WDATA,
    output logic [7:0]          M_WSTRB,
    output logic                M_WLAST,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic [ID_WIDTH-1:0] M_BID,
    input  logic [1:0]          M_BRESP,
    input  logic                M_BVALID,
    output logic                M_BREADY,

    output logic [1:0]          GRANT,
    output logic                BUSY
);

    logic [1:0]                     awvalid, wvalid, wlast, bready;
    logic [1:0][ID_WIDTH-1:0]       awid;
    logic [1:0][31:0]               awaddr;
    logic [1:0][7:0]                awlen;
    logic [1:0][2:0]                awsize;
    logic [1:0][1:0]                awburst;
    logic [1:0][63:0]               wdata;
    logic [1:0][7:0]                wstrb;

    logic [1:0]                     awready, wready, bvalid;
    logic [1:0][ID_WIDTH-1:0]       bid;
    logic [1:0][1:0]                bresp;

    assign awvalid = {S1_AWVALID, S0_AWVALID};
    assign wvalid  = {S1_WVALID,  S0_WVALID};
    assign wlast   = {S1_WLAST,   S0_WLAST};
    assign bready  = {S1_BREADY,  S0_BREADY};
    assign awid    = {S1_AWID,    S0_AWID};
    assign awaddr  = {S1_AWADDR,  S0_AWADDR};
    assign awlen   = {S1_AWLEN,   S0_AWLEN};
    assign awsize  = {S1_AWSIZE,  S0_AWSIZE};
    assign awburst = {S1_AWBURST, S0_AWBURST};
    assign wdata   = {S1_WDATA,   S0_WDATA};
    assign wstrb   = {S1_WSTRB,   S0_WSTRB};

    assign S0_AWREADY = awready[M0];
    assign S1_AWREADY = awready[M1];
    assign S0_WREADY  = wready[M0];
    assign S1_WREADY  = wready[M1];
    assign S0_BVALID  = bvalid[M0];
    assign S1_BVALID  = bvalid[M1];
    assign S0_BID     = bid[M0];
    assign S1_BID     = bid[M1];
    assign S0_BRESP   = bresp[M0];
    assign S1_BRESP   = bresp[M1];

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] pick;
    logic       last_w;
    logic       sel;
    logic       in_aw, in_w, in_b;

`ifdef AHA_AXI_WR_ARB_FIXED_PRIO_EN
    assign last_w = 1'b1;
`else
    logic last_q, last_d;
    assign last_w = last_q;
`endif

    aha_rr_arb2 u_pick (
        .req  (awvalid),
        .last (last_w),
        .gnt  (pick)
    );

    assign sel   = grant_q[M1];
    assign in_aw = (state_q == ST_AW);
    assign in_w  = (state_q == ST_W);
    assign in_b  = (state_q == ST_B);
    assign GRANT = grant_q;
    assign BUSY  = (state_q != ST_IDLE);

    // Payload muxes follow the registered owner; only the VALID/READY
    // strobes are gated by state, so forwarding is purely combinational.
    always_comb begin
        M_AWID    = awid[sel];
        M_AWADDR  = awaddr[sel];
        M_AWLEN   = awlen[sel];
        M_AWSIZE  = awsize[sel];
        M_AWBURST = awburst[sel];
        M_AWVALID = in_aw & awvalid[sel];
        M_WDATA   = wdata[sel];
        M_WSTRB   = wstrb[sel];
        M_WLAST   = wlast[sel];
        M_WVALID  = in_w & wvalid[sel];
        M_BREADY  = in_b & bready[sel];

        awready = '0;
        wready  = '0;
        bvalid  = '0;
        bid     = '0;
        bresp   = '0;
        for (int n = 0; n < 2; n++) begin
            awready[n] = in_aw & grant_q[n] & M_AWREADY;
            wready[n]  = in_w  & grant_q[n] & M_WREADY;
            bvalid[n]  = in_b  & grant_q[n] & M_BVALID;
            bid[n]     = (in_b & grant_q[n]) ? M_BID   : '0;
            bresp[n]   = (in_b & grant_q[n]) ? M_BRESP : BRESP_OKAY;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef AHA_AXI_WR_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|awvalid) begin
                    grant_d = pick;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (M_AWVALID && M_AWREADY)
                    state_d = ST_W;
            end
            ST_W: begin
                // WLAST alone ends the burst; AWLEN is not tracked.
                if (M_WVALID && M_WREADY && M_WLAST)
                    state_d = ST_B;
            end
            ST_B: begin
                if (M_BVALID && M_BREADY) begin
`ifndef AHA_AXI_WR_ARB_FIXED_PRIO_EN
                    last_d  = sel;
`endif
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
`ifndef AHA_AXI_WR_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifndef AHA_AXI_WR_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_aha_axi_wr_arbiter.sv
// Directed bench for aha_axi_wr_arbiter; expectations follow
// AHA_AXI_WR_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_aha_axi_wr_arbiter;

    localparam int IDW = 4;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [IDW-1:0]  S0_AWID, S1_AWID, M_AWID, S0_BID, S1_BID, M_BID;
    logic [31:0]     S0_AWADDR, S1_AWADDR, M_AWADDR;
    logic [7:0]      S0_AWLEN, S1_AWLEN, M_AWLEN;
    logic [2:0]      S0_AWSIZE, S1_AWSIZE, M_AWSIZE;
    logic [1:0]      S0_AWBURST, S1_AWBURST, M_AWBURST;
    logic            S0_AWVALID, S1_AWVALID, M_AWVALID;
    logic            S0_AWREADY, S1_AWREADY, M_AWREADY;
    logic [63:0]     S0_WDATA, S1_WDATA, M_WDATA;
    logic [7:0]      S0_WSTRB, S1_WSTRB, M_WSTRB;
    logic            S0_WLAST, S1_WLAST, M_WLAST;
    logic            S0_WVALID, S1_WVALID, M_WVALID;
    logic            S0_WREADY, S1_WREADY, M_WREADY;
    logic [1:0]      S0_BRESP, S1_BRESP, M_BRESP;
    logic            S0_BVALID, S1_BVALID, M_BVALID;
    logic            S0_BREADY, S1_BREADY, M_BREADY;
    logic [1:0]      GRANT;
    logic            BUSY;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 ACLK = ~ACLK;

    aha_axi_wr_arbiter #(.ID_WIDTH(IDW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S0_AWID(S0_AWID), .S0_AWADDR(S0_AWADDR), .S0_AWLEN(S0_AWLEN),
        .S0_AWSIZE(S0_AWSIZE), .S0_AWBURST(S0_AWBURST),
        .S0_AWVALID(S0_AWVALID), .S0_AWREADY(S0_AWREADY),
        .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB), .S0_WLAST(S0_WLAST),
        .S0_WVALID(S0_WVALID), .S0_WREADY(S0_WREADY),
        .S0_BID(S0_BID), .S0_BRESP(S0_BRESP), .S0_BVALID(S0_BVALID), .S0_BREADY(S0_BREADY),
        .S1_AWID(S1_AWID), .S1_AWADDR(S1_AWADDR), .S1_AWLEN(S1_AWLEN),
        .S1_AWSIZE(S1_AWSIZE), .S1_AWBURST(S1_AWBURST),
        .S1_AWVALID(S1_AWVALID), .S1_AWREADY(S1_AWREADY),
        .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB), .S1_WLAST(S1_WLAST),
        .S1_WVALID(S1_WVALID), .S1_WREADY(S1_WREADY),
        .S1_BID(S1_BID), .S1_BRESP(S1_BRESP), .S1_BVALID(S1_BVALID), .S1_BREADY(S1_BREADY),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
        .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [63:0] pat(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    logic [63:0] rx [16];
    int          nrx, k, cyc, w;
    logic        acc;

    initial begin
        ARESETn = 1'b0;
        {S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST, S0_AWVALID} = '0;
        {S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST, S1_AWVALID} = '0;
        {S0_WDATA, S0_WSTRB, S0_WLAST, S0_WVALID, S0_BREADY} = '0;
        {S1_WDATA, S1_WSTRB, S1_WLAST, S1_WVALID, S1_BREADY} = '0;
        {M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID} = '0;
        tick();
        tick();
        chk("rst_grant", GRANT, 2'b00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_strobes", {M_AWVALID, M_WVALID, M_BREADY, S0_AWREADY, S0_WREADY,
                            S0_BVALID, S1_AWREADY, S1_WREADY, S1_BVALID}, '0);
        ARESETn = 1'b1;

        // Tie: both masters keep requesting through three transactions.
        S0_AWADDR = 32'h100; S1_AWADDR = 32'h200;
        S0_WDATA  = 64'hA0;  S1_WDATA  = 64'hB1;
        S0_WLAST  = 1'b1;    S1_WLAST  = 1'b1;
        S0_WVALID = 1'b1;    S1_WVALID = 1'b1;
        S0_BREADY = 1'b1;    S1_BREADY = 1'b1;
        S0_AWVALID = 1'b1;   S1_AWVALID = 1'b1;
        M_AWREADY = 1'b1;    M_WREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
`ifdef AHA_AXI_WR_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = i % 2;
`endif
            M_BVALID = 1'b0;
            tick();
            chk($sformatf("tie%0d_grant", i), GRANT, (w == 1) ? 2'b10 : 2'b01);
            chk($sformatf("tie%0d_awaddr", i), M_AWADDR, (w == 1) ? 32'h200 : 32'h100);
            tick();
            chk($sformatf("tie%0d_wdata", i), M_WDATA, (w == 1) ? 64'hB1 : 64'hA0);
            chk($sformatf("tie%0d_loser_wready", i), (w == 1) ? S0_WREADY : S1_WREADY, 1'b0);
            tick();
            M_BVALID = 1'b1;
            #1;
            chk($sformatf("tie%0d_bvalid", i), {S1_BVALID, S0_BVALID}, (w == 1) ? 2'b10 : 2'b01);
            tick();
            chk($sformatf("tie%0d_idle", i), BUSY, 1'b0);
        end
        {S0_AWVALID, S1_AWVALID, S0_WVALID, S1_WVALID, S0_WLAST, S1_WLAST} = '0;
        {S0_BREADY, S1_BREADY, M_BVALID} = '0;
        tick();

        // Single master, 4-beat burst from S0.
        S0_AWID = 4'h3; S0_AWADDR = 32'h1000; S0_AWLEN = 8'd3;
        S0_AWSIZE = 3'd3; S0_AWBURST = 2'd1; S0_AWVALID = 1'b1;
        #1;
        chk("s0_idle_no_awvalid", M_AWVALID, 1'b0);
        tick();
        chk("s0_awvalid", M_AWVALID, 1'b1);
        chk("s0_aw_payload", {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST},
            {4'h3, 32'h1000, 8'd3, 3'd3, 2'd1});
        chk("s0_awready", {S1_AWREADY, S0_AWREADY}, 2'b01);
        tick();
        S0_AWVALID = 1'b0;
        for (int b = 0; b < 4; b++) begin
            S0_WDATA = pat(b + 16); S0_WSTRB = 8'hFF; S0_WLAST = (b == 3); S0_WVALID = 1'b1;
            #1;
            chk($sformatf("s0_beat%0d", b), {M_WVALID, M_WLAST, M_WDATA},
                {1'b1, (b == 3) ? 1'b1 : 1'b0, pat(b + 16)});
            chk($sformatf("s0_beat%0d_rdy", b), {GRANT, S1_WREADY, S0_WREADY}, 4'b0101);
            tick();
        end
        S0_WVALID = 1'b0; S0_WLAST = 1'b0;
        M_BVALID = 1'b1; M_BID = 4'h3; M_BRESP = 2'b00; S0_BREADY = 1'b1;
        #1;
        chk("s0_b", {S0_BVALID, S0_BID, S0_BRESP, S1_BVALID, M_BREADY}, {1'b1, 4'h3, 2'b00, 1'b0, 1'b1});
        tick();
        chk("s0_done", {BUSY, GRANT}, 3'b000);
        M_BVALID = 1'b0; S0_BREADY = 1'b0;

        // Backpressure: S1 8-beat burst, M_WREADY toggling, B held off.
        S1_AWADDR = 32'h3000; S1_AWLEN = 8'd7; S1_AWVALID = 1'b1;
        tick();
        chk("bp_grant", GRANT, 2'b10);
        tick();
        S1_AWVALID = 1'b0;
        k = 0; nrx = 0; cyc = 0;
        while (k < 8 && cyc < 40) begin
            S1_WVALID = 1'b1; S1_WDATA = pat(k); S1_WLAST = (k == 7);
            M_WREADY = (cyc % 2 == 1);
            #1;
            if (M_WVALID && M_WREADY && nrx < 16) begin
                rx[nrx] = M_WDATA;
                nrx++;
            end
            acc = S1_WREADY;
            tick();
            if (acc) k++;
            cyc++;
        end
        S1_WVALID = 1'b0; S1_WLAST = 1'b0; M_WREADY = 1'b1;
        chk("bp_beats", 64'(nrx), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("bp_rx%0d", i), rx[i], pat(i));
        M_BVALID = 1'b1; M_BID = 4'h0; S1_BREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_hold%0d", i), {BUSY, M_BREADY, S1_BVALID, S0_BVALID}, 4'b1010);
            tick();
        end
        S1_BREADY = 1'b1;
        #1;
        chk("bp_bready", M_BREADY, 1'b1);
        tick();
        chk("bp_done", BUSY, 1'b0);
        M_BVALID = 1'b0; S1_BREADY = 1'b0;

        // Early W from S1, plus ID passthrough.
        S1_WDATA = 64'hDEAD_BEEF_0123_4567; S1_WLAST = 1'b1; S1_WVALID = 1'b1;
        #1;
        chk("ew_idle0_wready", {M_WVALID, S1_WREADY}, 2'b00);
        tick();
        chk("ew_idle1_wready", {M_WVALID, S1_WREADY}, 2'b00);
        S1_AWID = 4'hA; S1_AWADDR = 32'h5000; S1_AWLEN = 8'd0; S1_AWVALID = 1'b1;
        tick();
        chk("ew_aw_wready", {M_WVALID, S1_WREADY}, 2'b00);
        chk("ew_awid", M_AWID, 4'hA);
        tick();
        S1_AWVALID = 1'b0;
        #1;
        chk("ew_w", {S1_WREADY, M_WVALID, M_WLAST, M_WDATA}, {3'b111, 64'hDEAD_BEEF_0123_4567});
        tick();
        S1_WVALID = 1'b0; S1_WLAST = 1'b0;
        M_BVALID = 1'b1; M_BID = 4'hA; M_BRESP = 2'b10; S1_BREADY = 1'b1;
        #1;
        chk("id_s1_b", {S1_BVALID, S1_BID, S1_BRESP}, {1'b1, 4'hA, 2'b10});
        chk("id_s0_b", {S0_BVALID, S0_BID, S0_BRESP}, '0);
        tick();
        M_BVALID = 1'b0; S1_BREADY = 1'b0;

        // Reset after beat 2 of a 4-beat S0 burst.
        S0_AWADDR = 32'h6000; S0_AWLEN = 8'd3; S0_AWVALID = 1'b1;
        tick();
        tick();
        S0_AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            S0_WDATA = pat(b + 32); S0_WLAST = 1'b0; S0_WVALID = 1'b1;
            tick();
        end
        ARESETn = 1'b0; S0_AWVALID = 1'b1; M_BVALID = 1'b1;
        tick();
        chk("mr_strobes", {M_AWVALID, M_WVALID, M_BREADY, S0_AWREADY, S0_WREADY,
                           S0_BVALID, S1_AWREADY, S1_WREADY, S1_BVALID}, '0);
        chk("mr_grant_busy", {GRANT, BUSY}, 3'b000);
        ARESETn = 1'b1;
        {S0_AWVALID, S0_WVALID, M_BVALID} = '0;
        S1_AWADDR = 32'h4000; S1_AWVALID = 1'b1;
        tick();
        chk("mr_s1_aw", {GRANT, M_AWVALID, M_AWADDR}, {2'b10, 1'b1, 32'h4000});
        tick();
        S1_AWVALID = 1'b0;
        S1_WDATA = 64'h4444; S1_WLAST = 1'b1; S1_WVALID = 1'b1;
        #1;
        chk("mr_s1_w", {M_WVALID, M_WDATA}, {1'b1, 64'h4444});
        tick();
        S1_WVALID = 1'b0; S1_WLAST = 1'b0;
        M_BVALID = 1'b1; M_BRESP = 2'b00; S1_BREADY = 1'b1;
        #1;
        chk("mr_s1_b", {S1_BVALID, S1_BRESP}, 3'b100);
        tick();
        chk("mr_done", BUSY, 1'b0);
        M_BVALID = 1'b0; S1_BREADY = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
